// File: rtl/n64_cfg_cmd_arbiter.sv
// Shares the single CPU command slot between the N64 config interface (A) and the
// USB/debug link (B): pulsed requests are latched, served round-robin, and timed out.
module n64_cfg_cmd_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd8_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        n64_soft_reset,
  input  logic        a_cmd_request,
  input  logic [7:0]  a_cmd,
  input  logic [31:0] a_arg0,
  input  logic [31:0] a_arg1,
  input  logic        b_cmd_request,
  input  logic [7:0]  b_cmd,
  input  logic [31:0] b_arg0,
  input  logic [31:0] b_arg1,
  output logic        a_busy,
  output logic        a_done,
  output logic        a_error,
  output logic [31:0] a_result0,
  output logic [31:0] a_result1,
  output logic        a_overrun,
  output logic        b_busy,
  output logic        b_done,
  output logic        b_error,
  output logic [31:0] b_result0,
  output logic [31:0] b_result1,
  output logic        b_overrun,
  output logic        cpu_cmd_valid,
  input  logic        cpu_cmd_ready,
  output logic [7:0]  cpu_cmd,
  output logic [31:0] cpu_arg0,
  output logic [31:0] cpu_arg1,
  output logic        cpu_cmd_src,
  input  logic        cpu_done,
  input  logic        cpu_error,
  input  logic [31:0] cpu_result0,
  input  logic [31:0] cpu_result1
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_EXEC  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state_r;
  logic        pend_a_r;
  logic        pend_b_r;
  logic        in_service_r;
  logic        last_src_r;
  logic [7:0]  cmd_a_r;
  logic [31:0] arg0_a_r;
  logic [31:0] arg1_a_r;
  logic [7:0]  cmd_b_r;
  logic [31:0] arg0_b_r;
  logic [31:0] arg1_b_r;
  logic [23:0] timer_r;

  logic        grant_a_s;
  logic        grant_b_s;
  logic        expired_s;
  logic        finish_s;
  logic        finish_err_s;
  logic        finish_res_s;

  // cpu_cmd_src doubles as the in-service source since it is held until completion
  assign a_busy    = pend_a_r | (in_service_r & ~cpu_cmd_src);
  assign b_busy    = pend_b_r | (in_service_r & cpu_cmd_src);
  assign expired_s = (timer_r == (TIMEOUT_CYCLES - 24'd1));

  // Round-robin grant; a soft-reset cycle masks A's pending request
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (pend_a_r && !n64_soft_reset && pend_b_r) begin
      if (last_src_r) begin
        grant_a_s = 1'b1;
      end else begin
        grant_b_s = 1'b1;
      end
    end else if (pend_a_r && !n64_soft_reset) begin
      grant_a_s = 1'b1;
    end else if (pend_b_r) begin
      grant_b_s = 1'b1;
    end else begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end
  end

  // Completion decode: cpu_done in S_EXEC beats a simultaneous timeout
  always_comb begin
    finish_s     = 1'b0;
    finish_err_s = 1'b0;
    finish_res_s = 1'b0;
    if ((state_r == S_EXEC) && cpu_done) begin
      finish_s     = 1'b1;
      finish_err_s = cpu_error;
      finish_res_s = ~cpu_error;
    end else if (((state_r == S_ISSUE) || (state_r == S_EXEC)) && expired_s) begin
      finish_s     = 1'b1;
      finish_err_s = 1'b1;
      finish_res_s = 1'b0;
    end else begin
      finish_s     = 1'b0;
      finish_err_s = 1'b0;
      finish_res_s = 1'b0;
    end
  end

  // Request capture, arbitration FSM, CPU handshake, timeout and requester status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= S_IDLE;
      pend_a_r      <= 1'b0;
      pend_b_r      <= 1'b0;
      in_service_r  <= 1'b0;
      last_src_r    <= 1'b1;
      cmd_a_r       <= 8'd0;
      arg0_a_r      <= 32'd0;
      arg1_a_r      <= 32'd0;
      cmd_b_r       <= 8'd0;
      arg0_b_r      <= 32'd0;
      arg1_b_r      <= 32'd0;
      timer_r       <= 24'd0;
      a_done        <= 1'b0;
      a_error       <= 1'b0;
      a_result0     <= 32'd0;
      a_result1     <= 32'd0;
      a_overrun     <= 1'b0;
      b_done        <= 1'b0;
      b_error       <= 1'b0;
      b_result0     <= 32'd0;
      b_result1     <= 32'd0;
      b_overrun     <= 1'b0;
      cpu_cmd_valid <= 1'b0;
      cpu_cmd       <= 8'd0;
      cpu_arg0      <= 32'd0;
      cpu_arg1      <= 32'd0;
      cpu_cmd_src   <= 1'b0;
    end else begin
      a_done    <= 1'b0;
      b_done    <= 1'b0;
      a_overrun <= a_cmd_request & a_busy;
      b_overrun <= b_cmd_request & b_busy;

      if (n64_soft_reset) begin
        pend_a_r <= 1'b0;
        a_error  <= 1'b0;
      end else if (a_cmd_request && !a_busy) begin
        pend_a_r <= 1'b1;
        cmd_a_r  <= a_cmd;
        arg0_a_r <= a_arg0;
        arg1_a_r <= a_arg1;
      end

      if (b_cmd_request && !b_busy) begin
        pend_b_r <= 1'b1;
        cmd_b_r  <= b_cmd;
        arg0_b_r <= b_arg0;
        arg1_b_r <= b_arg1;
      end

      case (state_r)
        S_IDLE: begin
          if (grant_a_s || grant_b_s) begin
            state_r       <= S_ISSUE;
            in_service_r  <= 1'b1;
            cpu_cmd_valid <= 1'b1;
            cpu_cmd_src   <= grant_b_s;
            timer_r       <= 24'd0;
            if (grant_b_s) begin
              pend_b_r <= 1'b0;
              cpu_cmd  <= cmd_b_r;
              cpu_arg0 <= arg0_b_r;
              cpu_arg1 <= arg1_b_r;
            end else begin
              pend_a_r <= 1'b0;
              cpu_cmd  <= cmd_a_r;
              cpu_arg0 <= arg0_a_r;
              cpu_arg1 <= arg1_a_r;
            end
          end
        end
        S_ISSUE: begin
          if (finish_s) begin
            cpu_cmd_valid <= 1'b0;
            state_r       <= S_RESP;
          end else if (cpu_cmd_ready) begin
            cpu_cmd_valid <= 1'b0;
            state_r       <= S_EXEC;
            timer_r       <= timer_r + 24'd1;
          end else begin
            timer_r <= timer_r + 24'd1;
          end
        end
        S_EXEC: begin
          if (finish_s) begin
            state_r <= S_RESP;
          end else begin
            timer_r <= timer_r + 24'd1;
          end
        end
        S_RESP: begin
          in_service_r <= 1'b0;
          last_src_r   <= cpu_cmd_src;
          state_r      <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase

      // Placed last so a completing A command overrides the soft-reset error clear
      if (finish_s) begin
        if (cpu_cmd_src) begin
          b_done  <= 1'b1;
          b_error <= finish_err_s;
          if (finish_res_s) begin
            b_result0 <= cpu_result0;
            b_result1 <= cpu_result1;
          end
        end else begin
          a_done  <= 1'b1;
          a_error <= finish_err_s;
          if (finish_res_s) begin
            a_result0 <= cpu_result0;
            a_result1 <= cpu_result1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_n64_cfg_cmd_arbiter.sv
// Self-checking bench for n64_cfg_cmd_arbiter: scenario tasks with randomized commands
// and results, checked against a per-requester transaction model.
module tb_n64_cfg_cmd_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        n64_soft_reset = 1'b0;
  logic        a_cmd_request = 1'b0, b_cmd_request = 1'b0;
  logic [7:0]  a_cmd = 8'd0, b_cmd = 8'd0;
  logic [31:0] a_arg0 = 32'd0, a_arg1 = 32'd0, b_arg0 = 32'd0, b_arg1 = 32'd0;
  logic        a_busy, a_done, a_error, a_overrun;
  logic        b_busy, b_done, b_error, b_overrun;
  logic [31:0] a_result0, a_result1, b_result0, b_result1;
  logic        cpu_cmd_valid, cpu_cmd_src;
  logic        cpu_cmd_ready = 1'b0;
  logic [7:0]  cpu_cmd;
  logic [31:0] cpu_arg0, cpu_arg1;
  logic        cpu_done = 1'b0, cpu_error = 1'b0;
  logic [31:0] cpu_result0 = 32'd0, cpu_result1 = 32'd0;

  int checks = 0;
  int errors = 0;

  // Model: what each requester should report, and who was served last
  logic [31:0] m_res0 [2];
  logic [31:0] m_res1 [2];
  logic        m_err  [2];
  int          m_last;
  logic [7:0]  q_cmd  [2];
  logic [31:0] q_a0   [2];
  logic [31:0] q_a1   [2];

  n64_cfg_cmd_arbiter #(.TIMEOUT_CYCLES(24'd16)) dut (
    .clk(clk), .reset_n(reset_n), .n64_soft_reset(n64_soft_reset),
    .a_cmd_request(a_cmd_request), .a_cmd(a_cmd), .a_arg0(a_arg0), .a_arg1(a_arg1),
    .b_cmd_request(b_cmd_request), .b_cmd(b_cmd), .b_arg0(b_arg0), .b_arg1(b_arg1),
    .a_busy(a_busy), .a_done(a_done), .a_error(a_error),
    .a_result0(a_result0), .a_result1(a_result1), .a_overrun(a_overrun),
    .b_busy(b_busy), .b_done(b_done), .b_error(b_error),
    .b_result0(b_result0), .b_result1(b_result1), .b_overrun(b_overrun),
    .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_ready(cpu_cmd_ready), .cpu_cmd(cpu_cmd),
    .cpu_arg0(cpu_arg0), .cpu_arg1(cpu_arg1), .cpu_cmd_src(cpu_cmd_src),
    .cpu_done(cpu_done), .cpu_error(cpu_error),
    .cpu_result0(cpu_result0), .cpu_result1(cpu_result1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_res0[s] = 32'd0;
      m_res1[s] = 32'd0;
      m_err[s]  = 1'b0;
    end
    m_last = 1;
  endtask

  task automatic model_complete(input int s, input logic err, input logic [31:0] r0, input logic [31:0] r1);
    m_err[s] = err;
    if (!err) begin
      m_res0[s] = r0;
      m_res1[s] = r1;
    end
    m_last = s;
  endtask

  task automatic new_args(input int s);
    q_cmd[s] = 8'($urandom);
    q_a0[s]  = $urandom;
    q_a1[s]  = $urandom;
  endtask

  task automatic request(input logic ra, input logic rb);
    a_cmd_request = ra; a_cmd = q_cmd[0]; a_arg0 = q_a0[0]; a_arg1 = q_a1[0];
    b_cmd_request = rb; b_cmd = q_cmd[1]; b_arg0 = q_a0[1]; b_arg1 = q_a1[1];
    tick();
    a_cmd_request = 1'b0;
    b_cmd_request = 1'b0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    model_reset();
  endtask

  // CPU side: wait for an offer, accept it, then complete; returns what was offered
  task automatic cpu_serve(input int rdy_dly, input int done_dly, input logic err,
                           input logic [31:0] r0, input logic [31:0] r1,
                           output logic [7:0] o_cmd, output logic [31:0] o_a0,
                           output logic [31:0] o_a1, output logic o_src, output logic o_ok);
    int n;
    n = 0;
    o_ok = 1'b0; o_cmd = 8'd0; o_a0 = 32'd0; o_a1 = 32'd0; o_src = 1'b0;
    while (!cpu_cmd_valid && n < 40) begin
      tick();
      n++;
    end
    if (cpu_cmd_valid) begin
      o_cmd = cpu_cmd; o_a0 = cpu_arg0; o_a1 = cpu_arg1; o_src = cpu_cmd_src;
      repeat (rdy_dly) tick();
      cpu_cmd_ready = 1'b1;
      tick();
      cpu_cmd_ready = 1'b0;
      repeat (done_dly) tick();
      cpu_done = 1'b1; cpu_error = err; cpu_result0 = r0; cpu_result1 = r1;
      tick();
      cpu_done = 1'b0; cpu_error = 1'b0;
      o_ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    checks++; if ({a_busy, a_done, a_error, a_overrun, b_busy, b_done, b_error, b_overrun, cpu_cmd_valid, cpu_cmd_src} !== 10'd0) begin
      errors++; $display("FAIL reset_flags got=%b exp=0", {a_busy, a_done, a_error, a_overrun, b_busy, b_done, b_error, b_overrun, cpu_cmd_valid, cpu_cmd_src}); end
    checks++; if ((a_result0 | a_result1 | b_result0 | b_result1) !== 32'd0) begin
      errors++; $display("FAIL reset_results got=%h/%h/%h/%h exp=0", a_result0, a_result1, b_result0, b_result1); end
    checks++; if ((cpu_arg0 | cpu_arg1 | {24'd0, cpu_cmd}) !== 32'd0) begin
      errors++; $display("FAIL reset_cpu_bus got=%h/%h/%h exp=0", cpu_cmd, cpu_arg0, cpu_arg1); end
  endtask

  task automatic test_basic();
    logic [31:0] r1;
    r1 = $urandom;
    q_cmd[0] = 8'h10; q_a0[0] = 32'h1234_5678; q_a1[0] = $urandom;
    cpu_cmd_ready = 1'b1;
    request(1'b1, 1'b0);
    checks++; if (a_busy !== 1'b1 || cpu_cmd_valid !== 1'b0) begin
      errors++; $display("FAIL basic_req busy=%b valid=%b exp busy=1 valid=0", a_busy, cpu_cmd_valid); end
    tick();
    checks++; if (cpu_cmd_valid !== 1'b1 || cpu_cmd !== 8'h10 || cpu_arg0 !== 32'h1234_5678 || cpu_arg1 !== q_a1[0] || cpu_cmd_src !== 1'b0) begin
      errors++; $display("FAIL basic_offer valid=%b cmd=%h a0=%h a1=%h src=%b exp 1/10/12345678/%h/0", cpu_cmd_valid, cpu_cmd, cpu_arg0, cpu_arg1, cpu_cmd_src, q_a1[0]); end
    tick();
    cpu_cmd_ready = 1'b0;
    checks++; if (cpu_cmd_valid !== 1'b0) begin
      errors++; $display("FAIL basic_handshake valid=%b exp=0", cpu_cmd_valid); end
    tick();
    cpu_done = 1'b1; cpu_error = 1'b0; cpu_result0 = 32'hDEAD_BEEF; cpu_result1 = r1;
    tick();
    cpu_done = 1'b0;
    model_complete(0, 1'b0, 32'hDEAD_BEEF, r1);
    checks++; if (a_done !== 1'b1 || a_result0 !== m_res0[0] || a_result1 !== m_res1[0] || a_error !== m_err[0]) begin
      errors++; $display("FAIL basic_done done=%b r0=%h r1=%h err=%b exp 1/%h/%h/%b", a_done, a_result0, a_result1, a_error, m_res0[0], m_res1[0], m_err[0]); end
    checks++; if (b_done !== 1'b0 || b_busy !== 1'b0 || b_error !== m_err[1] || b_result0 !== m_res0[1] || b_result1 !== m_res1[1]) begin
      errors++; $display("FAIL basic_b_quiet done=%b busy=%b err=%b r0=%h r1=%h exp unchanged", b_done, b_busy, b_error, b_result0, b_result1); end
    checks++; if (a_busy !== 1'b1) begin
      errors++; $display("FAIL basic_busy_hold got=%b exp=1", a_busy); end
    tick();
    checks++; if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL basic_after done=%b busy=%b exp 0/0", a_done, a_busy); end
  endtask

  task automatic test_overrun();
    logic [7:0]  f_cmd, o_cmd;
    logic [31:0] f_a0, f_a1, o_a0, o_a1, r0, r1;
    logic        o_src, ok;
    int          extra;
    new_args(0);
    f_cmd = q_cmd[0]; f_a0 = q_a0[0]; f_a1 = q_a1[0];
    request(1'b1, 1'b0);
    q_cmd[0] = f_cmd + 8'd1; q_a0[0] = ~f_a0; q_a1[0] = ~f_a1;
    request(1'b1, 1'b0);
    checks++; if (a_overrun !== 1'b1 || b_overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_pulse a=%b b=%b exp 1/0", a_overrun, b_overrun); end
    tick();
    checks++; if (a_overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_single got=%b exp=0", a_overrun); end
    r0 = $urandom; r1 = $urandom;
    cpu_serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b0, r0, r1, o_cmd, o_a0, o_a1, o_src, ok);
    model_complete(0, 1'b0, r0, r1);
    checks++; if (ok !== 1'b1 || o_cmd !== f_cmd || o_a0 !== f_a0 || o_a1 !== f_a1 || o_src !== 1'b0) begin
      errors++; $display("FAIL overrun_kept ok=%b cmd=%h a0=%h a1=%h src=%b exp 1/%h/%h/%h/0", ok, o_cmd, o_a0, o_a1, o_src, f_cmd, f_a0, f_a1); end
    checks++; if (a_done !== 1'b1 || a_result0 !== m_res0[0] || a_result1 !== m_res1[0]) begin
      errors++; $display("FAIL overrun_done done=%b r0=%h r1=%h exp 1/%h/%h", a_done, a_result0, a_result1, m_res0[0], m_res1[0]); end
    extra = 0;
    repeat (8) begin
      tick();
      if (cpu_cmd_valid) extra++;
    end
    checks++; if (extra !== 0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL overrun_one_handshake extra_valid_cycles=%0d busy=%b exp 0/0", extra, a_busy); end
  endtask

  task automatic test_timeout();
    logic [7:0]  o_cmd;
    logic [31:0] o_a0, o_a1, r0, r1;
    logic        o_src, ok;
    int          early;
    new_args(0);
    request(1'b1, 1'b0);
    tick();
    checks++; if (cpu_cmd_valid !== 1'b1) begin
      errors++; $display("FAIL timeout_grant valid=%b exp=1", cpu_cmd_valid); end
    cpu_cmd_ready = 1'b1;
    tick();
    cpu_cmd_ready = 1'b0;
    early = 0;
    repeat (14) begin
      tick();
      if (a_done) early++;
    end
    checks++; if (early !== 0) begin
      errors++; $display("FAIL timeout_early done_cycles=%0d exp=0", early); end
    tick();
    model_complete(0, 1'b1, 32'd0, 32'd0);
    checks++; if (a_done !== 1'b1 || a_error !== 1'b1 || a_result0 !== m_res0[0] || a_result1 !== m_res1[0]) begin
      errors++; $display("FAIL timeout_expire done=%b err=%b r0=%h r1=%h exp 1/1/%h/%h", a_done, a_error, a_result0, a_result1, m_res0[0], m_res1[0]); end
    tick();
    checks++; if (a_done !== 1'b0 || a_busy !== 1'b0 || a_error !== 1'b1) begin
      errors++; $display("FAIL timeout_after done=%b busy=%b err=%b exp 0/0/1", a_done, a_busy, a_error); end
    new_args(0);
    request(1'b1, 1'b0);
    r0 = $urandom; r1 = $urandom;
    cpu_serve(0, 2, 1'b0, r0, r1, o_cmd, o_a0, o_a1, o_src, ok);
    model_complete(0, 1'b0, r0, r1);
    checks++; if (ok !== 1'b1 || a_done !== 1'b1 || a_error !== m_err[0] || a_result0 !== m_res0[0] || a_result1 !== m_res1[0]) begin
      errors++; $display("FAIL timeout_recover ok=%b done=%b err=%b r0=%h exp 1/1/%b/%h", ok, a_done, a_error, a_result0, m_err[0], m_res0[0]); end
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    int          pattern [5] = '{3, 2, 3, 1, 3};
    int          order [2];
    int          n;
    logic [7:0]  o_cmd;
    logic [31:0] o_a0, o_a1, r0, r1, g0, g1;
    logic        o_src, ok, err, gd, ge, od;
    apply_reset();
    for (int rnd = 0; rnd < 5; rnd++) begin
      n = 0;
      if (pattern[rnd] == 3) begin
        order[0] = (m_last == 0) ? 1 : 0;
        order[1] = 1 - order[0];
        n = 2;
      end else begin
        order[0] = (pattern[rnd] == 1) ? 0 : 1;
        n = 1;
      end
      new_args(0);
      new_args(1);
      request(pattern[rnd][0], pattern[rnd][1]);
      for (int k = 0; k < n; k++) begin
        if (k == 1) begin
          tick();
          checks++; if (cpu_cmd_valid !== 1'b0 || (order[0] == 0 ? a_busy : b_busy) !== 1'b0) begin
            errors++; $display("FAIL rr_gap round=%0d valid=%b busy=%b exp 0/0", rnd, cpu_cmd_valid, order[0] == 0 ? a_busy : b_busy); end
          tick();
          checks++; if (cpu_cmd_valid !== 1'b1) begin
            errors++; $display("FAIL rr_back_to_back round=%0d valid=%b exp=1", rnd, cpu_cmd_valid); end
        end
        err = ($urandom_range(0, 3) == 0);
        r0 = $urandom; r1 = $urandom;
        cpu_serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), err, r0, r1, o_cmd, o_a0, o_a1, o_src, ok);
        checks++; if (ok !== 1'b1 || o_src !== order[k][0] || o_cmd !== q_cmd[order[k]] || o_a0 !== q_a0[order[k]] || o_a1 !== q_a1[order[k]]) begin
          errors++; $display("FAIL rr_offer round=%0d k=%0d ok=%b src=%b cmd=%h a0=%h exp src=%0d cmd=%h a0=%h", rnd, k, ok, o_src, o_cmd, o_a0, order[k], q_cmd[order[k]], q_a0[order[k]]); end
        model_complete(order[k], err, r0, r1);
        if (order[k] == 0) begin
          gd = a_done; ge = a_error; g0 = a_result0; g1 = a_result1; od = b_done;
        end else begin
          gd = b_done; ge = b_error; g0 = b_result0; g1 = b_result1; od = a_done;
        end
        checks++; if (gd !== 1'b1 || od !== 1'b0 || ge !== m_err[order[k]] || g0 !== m_res0[order[k]] || g1 !== m_res1[order[k]]) begin
          errors++; $display("FAIL rr_result round=%0d src=%0d done=%b other=%b err=%b r0=%h r1=%h exp 1/0/%b/%h/%h", rnd, order[k], gd, od, ge, g0, g1, m_err[order[k]], m_res0[order[k]], m_res1[order[k]]); end
      end
      tick();
      tick();
    end
  endtask

  task automatic test_soft_reset();
    logic [7:0]  o_cmd;
    logic [31:0] o_a0, o_a1, r0, r1;
    logic        o_src, ok;
    int          seen;
    new_args(0);
    request(1'b1, 1'b0);
    cpu_serve(0, 0, 1'b1, 32'd0, 32'd0, o_cmd, o_a0, o_a1, o_src, ok);
    model_complete(0, 1'b1, 32'd0, 32'd0);
    checks++; if (ok !== 1'b1 || a_error !== 1'b1) begin
      errors++; $display("FAIL srst_setup ok=%b err=%b exp 1/1", ok, a_error); end
    tick();
    tick();
    new_args(1);
    request(1'b0, 1'b1);
    tick();
    cpu_cmd_ready = 1'b1;
    tick();
    cpu_cmd_ready = 1'b0;
    new_args(0);
    request(1'b1, 1'b0);
    checks++; if (a_busy !== 1'b1) begin
      errors++; $display("FAIL srst_a_pending busy=%b exp=1", a_busy); end
    n64_soft_reset = 1'b1;
    tick();
    n64_soft_reset = 1'b0;
    m_err[0] = 1'b0;
    checks++; if (a_busy !== 1'b0 || a_error !== m_err[0] || b_busy !== 1'b1) begin
      errors++; $display("FAIL srst_clear a_busy=%b a_err=%b b_busy=%b exp 0/0/1", a_busy, a_error, b_busy); end
    r0 = $urandom; r1 = $urandom;
    cpu_done = 1'b1; cpu_error = 1'b0; cpu_result0 = r0; cpu_result1 = r1;
    tick();
    cpu_done = 1'b0;
    model_complete(1, 1'b0, r0, r1);
    checks++; if (b_done !== 1'b1 || b_error !== m_err[1] || b_result0 !== m_res0[1] || b_result1 !== m_res1[1]) begin
      errors++; $display("FAIL srst_b_done done=%b err=%b r0=%h r1=%h exp 1/%b/%h/%h", b_done, b_error, b_result0, b_result1, m_err[1], m_res0[1], m_res1[1]); end
    seen = 0;
    repeat (8) begin
      tick();
      if (cpu_cmd_valid || a_done) seen++;
    end
    checks++; if (seen !== 0) begin
      errors++; $display("FAIL srst_a_dropped activity_cycles=%0d exp=0", seen); end
    new_args(0);
    request(1'b1, 1'b0);
    tick();
    cpu_cmd_ready = 1'b1;
    tick();
    cpu_cmd_ready = 1'b0;
    n64_soft_reset = 1'b1;
    tick();
    n64_soft_reset = 1'b0;
    r0 = $urandom | 32'd1; r1 = $urandom;
    cpu_done = 1'b1; cpu_error = 1'b0; cpu_result0 = r0; cpu_result1 = r1;
    tick();
    cpu_done = 1'b0;
    model_complete(0, 1'b0, r0, r1);
    checks++; if (a_done !== 1'b1 || a_error !== m_err[0] || a_result0 !== m_res0[0] || a_result1 !== m_res1[0]) begin
      errors++; $display("FAIL srst_in_service done=%b err=%b r0=%h exp 1/%b/%h", a_done, a_error, a_result0, m_err[0], m_res0[0]); end
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    logic [7:0]  o_cmd;
    logic [31:0] o_a0, o_a1, r0, r1;
    logic        o_src, ok;
    int          seen;
    new_args(0);
    request(1'b1, 1'b0);
    tick();
    cpu_cmd_ready = 1'b1;
    tick();
    cpu_cmd_ready = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if ({a_busy, a_done, a_error, a_overrun, b_busy, b_done, b_error, b_overrun, cpu_cmd_valid, cpu_cmd_src} !== 10'd0) begin
      errors++; $display("FAIL areset_flags got=%b exp=0", {a_busy, a_done, a_error, a_overrun, b_busy, b_done, b_error, b_overrun, cpu_cmd_valid, cpu_cmd_src}); end
    checks++; if ((a_result0 | a_result1 | b_result0 | b_result1 | cpu_arg0 | cpu_arg1 | {24'd0, cpu_cmd}) !== 32'd0) begin
      errors++; $display("FAIL areset_words a_r0=%h b_r0=%h cmd=%h exp 0", a_result0, b_result0, cpu_cmd); end
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    tick();
    reset_n = 1'b1;
    model_reset();
    seen = 0;
    repeat (5) begin
      tick();
      if (a_done || b_done || cpu_cmd_valid) seen++;
    end
    checks++; if (seen !== 0) begin
      errors++; $display("FAIL areset_no_done activity_cycles=%0d exp=0", seen); end
    new_args(1);
    request(1'b0, 1'b1);
    r0 = $urandom; r1 = $urandom;
    cpu_serve(1, 1, 1'b0, r0, r1, o_cmd, o_a0, o_a1, o_src, ok);
    model_complete(1, 1'b0, r0, r1);
    checks++; if (ok !== 1'b1 || o_src !== 1'b1 || o_cmd !== q_cmd[1] || b_done !== 1'b1 || b_result0 !== m_res0[1] || b_result1 !== m_res1[1] || b_error !== m_err[1]) begin
      errors++; $display("FAIL areset_fresh_b ok=%b src=%b cmd=%h done=%b r0=%h exp 1/1/%h/1/%h", ok, o_src, o_cmd, b_done, b_result0, q_cmd[1], m_res0[1]); end
    tick();
  endtask

  initial begin
    model_reset();
    for (int s = 0; s < 2; s++) begin
      q_cmd[s] = 8'd0; q_a0[s] = 32'd0; q_a1[s] = 32'd0;
    end
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_overrun();
    test_timeout();
    test_round_robin();
    test_soft_reset();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/n64_cfg_cmd_arbiter.md
# n64_cfg_cmd_arbiter

Shares the single CPU command slot between two command requesters: the N64 config register interface (requester A) and the USB/debug link (requester B). The block latches pulsed requests, arbitrates round-robin, hands one command at a time to the CPU-side handler through a valid/ready handshake, and waits for completion under a timeout. It returns busy, done, error and two 32-bit result words to the requester that was served. It sits between the N64 config register block, the USB command path and the CPU command interface.

## Interface
- TIMEOUT_CYCLES, 24'd8_000_000, clk cycles allowed from grant to cpu_done before the block aborts with an error; must be ≥ 2
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- n64_soft_reset  in  1  N64 soft reset; level-sensitive, sampled on clk
- a_cmd_request / b_cmd_request  in  1  single-cycle command request pulse
- a_cmd / b_cmd  in  8  command id, sampled with the request
- a_arg0, a_arg1 / b_arg0, b_arg1  in  32 each  command arguments, sampled with the request
- a_busy / b_busy  out  1  requester has a command pending or in service
- a_done / b_done  out  1  single-cycle completion pulse
- a_error / b_error  out  1  error status of the last completed command
- a_result0, a_result1 / b_result0, b_result1  out  32 each  result words of the last successful command
- a_overrun / b_overrun  out  1  single-cycle pulse: request dropped because the requester was busy
- cpu_cmd_valid  out  1  command offered to the CPU
- cpu_cmd_ready  in  1  CPU accepts the command
- cpu_cmd  out  8  command id
- cpu_arg0, cpu_arg1  out  32 each  arguments
- cpu_cmd_src  out  1  source of the command: 0 = A, 1 = B
- cpu_done  in  1  single-cycle completion pulse from the CPU
- cpu_error  in  1  error flag, qualified by cpu_done
- cpu_result0, cpu_result1  in  32 each  results, qualified by cpu_done

## Operation
- Per requester: a pending bit plus cmd/arg0/arg1 capture registers. A request while busy=0 sets pending and captures the inputs. A request while busy=1 is dropped, and the requester's overrun output pulses on the next cycle.
- busy = pending OR (in service AND source is this requester).
- States: S_IDLE, S_ISSUE, S_EXEC, S_RESP.
- S_IDLE: if any pending bit is set, grant and go to S_ISSUE. If both are pending, grant the requester not served last (last_src register, reset value 1, so A wins the first tie). On grant: clear that requester's pending bit, load the cpu_cmd/arg/src outputs, clear the timeout counter.
- S_ISSUE: cpu_cmd_valid=1 with all outputs held stable. When cpu_cmd_valid & cpu_cmd_ready, go to S_EXEC. cpu_done in this state is ignored.
- S_EXEC: on cpu_done, latch cpu_error into the source's error output. If cpu_error=0, also latch cpu_result0/1 into the source's result outputs; if cpu_error=1, results are left unchanged. Then go to S_RESP.
- Timeout: the counter runs during S_ISSUE and S_EXEC. When it reaches TIMEOUT_CYCLES-1 without cpu_done: set the source's error to 1, leave results unchanged, drop cpu_cmd_valid, go to S_RESP. If cpu_done arrives in the same cycle as expiry, cpu_done wins.
- S_RESP: pulse the source's done for one cycle, clear in-service, update last_src, return to S_IDLE.
- error is sticky until the next completion for that requester.
- n64_soft_reset: clears a pending bit and a_error. A command from A that is already granted completes normally. B is unaffected.
- Reset (async, reset_n low): state S_IDLE; all outputs 0 (busy, done, error, overrun, results, cpu_*); pending bits cleared; last_src=1. Reset mid-command abandons the command without a done pulse.

## Timing
- Request pulse at edge N: busy=1 from N+1; grant at edge N+1; cpu_cmd_valid=1 from N+2.
- Handshake at edge H: cpu_cmd_valid=0 from H+1.
- cpu_done at edge D: done=1 and error/results updated from D+1; busy=0 from D+2.
- Back-to-back: the next pending command is granted at D+2, so cpu_cmd_valid rises at D+3.
- A new request is accepted on the same edge at which busy falls (busy sampled as 0 at that edge).
- Overrun pulse: one cycle after the dropped request.

## Test plan
- A requests cmd=0x10, arg0=0x12345678; CPU ready immediately; cpu_done with result0=0xDEADBEEF two cycles later -> cpu_cmd_src=0, a_done single pulse, a_result0=0xDEADBEEF, a_error=0, b_* unchanged.
- A and B request on the same cycle after reset -> A served first, B granted at D+2; B then A then both again -> ties alternate.
- TIMEOUT_CYCLES=16, CPU accepts but never sends cpu_done -> exactly 16 cycles after grant: a_done pulse, a_error=1, a_result0/1 unchanged. The next A request with cpu_done, cpu_error=0 clears a_error.
- Second A request while a_busy=1 -> a_overrun pulses once, the captured command stays the first one, exactly one cpu handshake occurs.
- n64_soft_reset while A is pending and B is in service -> A is never issued, B completes normally; n64_soft_reset while A is in service -> A completes with a_done.
- reset_n asserted during S_EXEC -> all outputs 0 asynchronously, no done pulse; after release, a fresh B request completes normally.
